sdram_rw_test: RTL and testbench

SDRAM_RW_TEST -- requirements
Module: sdram_rw_test

---
 rtl/sdram_rw_test_pkg.sv | 17 +
 rtl/sdram_rw_test.sv | 97 +++++++++
 tb/tb_sdram_rw_test.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_rw_test_pkg.sv
// Shared definitions for the SDRAM write/read-back self test:
// FSM state encoding and default test sizing.
package sdram_rw_test_pkg;

  localparam int unsigned DEFAULT_DATA_W    = 16;
  localparam int unsigned DEFAULT_TEST_LEN  = 1024;
  localparam int unsigned DEFAULT_START_DLY = 20;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DELAY = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/sdram_rw_test.sv
// SDRAM self test: writes the pattern 1..TEST_LEN through the controller FIFO,
// reads it back, compares every word and flags any mismatch until reset.
module sdram_rw_test
  import sdram_rw_test_pkg::*;
#(
  parameter int unsigned DATA_W    = DEFAULT_DATA_W,
  parameter int unsigned TEST_LEN  = DEFAULT_TEST_LEN,
  parameter int unsigned START_DLY = DEFAULT_START_DLY
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic              wr_full,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  input  logic              rd_empty,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic              error_flag,
  output logic              test_done
);

  localparam int unsigned CNT_W = $clog2(TEST_LEN + 1);
  localparam int unsigned DLY_W = $clog2(START_DLY + 2);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TEST_LEN - 1);
  localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(TEST_LEN);

  state_e           state_q, state_d;
  logic [DLY_W-1:0] dly_cnt_q, dly_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, rd_cnt_q, cmp_cnt_q;
  logic             rd_vld_q, error_q, done_q;
  logic             dly_end, cmp_mismatch;

  // Last cycle of the start-up delay window.
  assign dly_end      = (32'(dly_cnt_q) + 32'd1) >= START_DLY;
  assign cmp_mismatch = rd_data != (DATA_W'(cmp_cnt_q) + DATA_W'(1));

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    dly_cnt_d = '0;
    case (state_q)
      ST_IDLE:  if (init_done) state_d = ST_DELAY;
      ST_DELAY: begin
        if (!init_done)   state_d = ST_IDLE;
        else if (dly_end) state_d = ST_WRITE;
        else              dly_cnt_d = dly_cnt_q + DLY_W'(1);
      end
      ST_WRITE: if (wr_en && (wr_cnt_q == LAST_IDX)) state_d = ST_READ;
      ST_READ:  if (rd_vld_q && (cmp_cnt_q == LAST_IDX)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Strobes react to FIFO flow control within the same cycle.
  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    if (state_q == ST_WRITE) begin
      wr_en   = !wr_full;
      wr_data = DATA_W'(wr_cnt_q) + DATA_W'(1);
    end
    if (state_q == ST_READ) rd_en = !rd_empty && (rd_cnt_q < LEN_C);
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      dly_cnt_q <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      cmp_cnt_q <= '0;
      rd_vld_q  <= 1'b0;
      error_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      dly_cnt_q <= dly_cnt_d;
      rd_vld_q  <= rd_en;
      if (wr_en) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      if (rd_en) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      if (rd_vld_q && (state_q == ST_READ)) begin
        cmp_cnt_q <= cmp_cnt_q + CNT_W'(1);
        if (cmp_mismatch) error_q <= 1'b1;
      end
      if (state_d == ST_DONE) done_q <= 1'b1;
    end
  end

  assign error_flag = error_q;
  assign test_done  = done_q;

endmodule

// File: tb/tb_sdram_rw_test.sv
// Bench for sdram_rw_test: loopback FIFO model plus a behavioural expectation
// model, checked every cycle under directed and randomized flow control.
module tb_sdram_rw_test;

  localparam int unsigned DW   = 16;
  localparam int unsigned LEN  = 8;
  localparam int unsigned SDLY = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          init_done = 1'b0;
  logic          wr_full = 1'b0;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_empty = 1'b1;
  logic          rd_en;
  logic [DW-1:0] rd_data = '0;
  logic          error_flag;
  logic          test_done;

  always #5 clk = ~clk;

  sdram_rw_test #(.DATA_W(DW), .TEST_LEN(LEN), .START_DLY(SDLY)) dut (
    .clk_50m   (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .wr_full   (wr_full),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_empty  (rd_empty),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .error_flag(error_flag),
    .test_done (test_done)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // External controller FIFO and the log of accepted writes.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] wlog[$];
  bit            pend_vld;
  logic [DW-1:0] pend_word;

  // Expectation model: progress counters of the test.
  int m_k, m_written, m_read, m_compared;
  bit m_started, m_err, m_done;

  // Scenario controls.
  int full_mode, empty_mode, corrupt_idx, init_low_n, drop_at, stall_left;
  bit stall_used, tgl, rel_pending, prev_init;
  int cyc, rise_cyc, first_wr_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    fifo_q.delete();
    wlog.delete();
    pend_vld = 0; pend_word = '0;
    m_k = 0; m_written = 0; m_read = 0; m_compared = 0;
    m_started = 0; m_err = 0; m_done = 0;
    stall_left = 0; stall_used = 0; tgl = 0; prev_init = 0;
    cyc = 0; rise_cyc = -1; first_wr_cyc = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_error_flag", error_flag, 0);
    chk("rst_test_done", test_done, 0);
    model_clear();
    rel_pending = 1;
  endtask

  // One clock cycle: drive inputs, compare outputs, advance both models.
  task automatic cycle();
    bit            stall_rd, vld_now, started_now, writing, reading;
    bit            exp_wr_en, exp_rd_en;
    logic [31:0]   exp_wr_data;
    logic [DW-1:0] drv_rd;
    @(negedge clk);
    if (rel_pending) begin rst_n = 1'b1; rel_pending = 0; end
    init_done = (cyc >= init_low_n) && (cyc != drop_at);
    if (init_done && !prev_init) rise_cyc = cyc;
    prev_init = init_done;
    if (full_mode == 1 && m_written == 3 && !stall_used) begin
      stall_left = 5; stall_used = 1;
    end
    case (full_mode)
      1:       wr_full = (stall_left > 0);
      2:       wr_full = ($urandom_range(0, 2) == 0);
      default: wr_full = 1'b0;
    endcase
    if (stall_left > 0) stall_left--;
    tgl = !tgl;
    case (empty_mode)
      1:       stall_rd = tgl;
      2:       stall_rd = ($urandom_range(0, 2) == 0);
      default: stall_rd = 0;
    endcase
    rd_empty = (fifo_q.size() == 0) || stall_rd;
    vld_now  = pend_vld;
    drv_rd   = pend_vld ? pend_word : DW'($urandom);
    rd_data  = drv_rd;
    #1;
    started_now = m_started || (m_k >= int'(SDLY) + 1);
    writing     = started_now && (m_written < LEN);
    exp_wr_en   = writing && !wr_full;
    exp_wr_data = writing ? 32'(m_written + 1) : 32'd0;
    reading     = (m_written == LEN) && !m_done;
    exp_rd_en   = reading && !rd_empty && (m_read < LEN);
    chk("wr_en", wr_en, exp_wr_en);
    chk("wr_data", wr_data, exp_wr_data);
    chk("rd_en", rd_en, exp_rd_en);
    chk("error_flag", error_flag, m_err);
    chk("test_done", test_done, m_done);
    if (rd_en) begin
      if (fifo_q.size() > 0) pend_word = fifo_q.pop_front();
      else                   pend_word = DW'($urandom);
    end
    if (wr_en) begin
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      wlog.push_back(wr_data);
      fifo_q.push_back((wlog.size() == corrupt_idx) ? DW'(0) : wr_data);
    end
    pend_vld = rd_en;
    if (!started_now) m_k = init_done ? m_k + 1 : 0;
    else              m_started = 1;
    if (vld_now) begin
      if (drv_rd != DW'(m_compared + 1)) m_err = 1;
      m_compared++;
      if (m_compared == LEN) m_done = 1;
    end
    if (exp_wr_en) m_written++;
    if (exp_rd_en) m_read++;
    cyc++;
  endtask

  task automatic run_test(input int bound, input int extra);
    int n = 0;
    while (!m_done && n < bound) begin cycle(); n++; end
    if (!m_done) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout: test_done not expected after %0d cycles", bound);
    end
    repeat (extra) cycle();
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_nwords"}, wlog.size(), LEN);
    for (int i = 0; i < wlog.size(); i++) chk({tag, "_word"}, wlog[i], i + 1);
  endtask

  task automatic set_scn(input int fm, input int em, input int ci, input int il, input int da);
    full_mode = fm; empty_mode = em; corrupt_idx = ci; init_low_n = il; drop_at = da;
  endtask

  initial begin
    set_scn(0, 0, 0, 0, -1);
    do_reset();

    // Clean run, then stray words left in the FIFO after completion.
    run_test(200, 2);
    chk("s1_done", test_done, 1);
    chk("s1_error", error_flag, 0);
    chk("s1_first_wr_ofs", first_wr_cyc - rise_cyc, SDLY + 1);
    check_log("s1");
    for (int i = 0; i < 3; i++) fifo_q.push_back(DW'(16'hA5A0 + i));
    repeat (10) cycle();
    chk("s1_fifo_left", fifo_q.size(), 3);

    // Five-cycle write stall after word 3.
    set_scn(1, 0, 0, 0, -1);
    do_reset();
    run_test(200, 2);
    check_log("s2");
    chk("s2_error", error_flag, 0);

    // Word 3 corrupted in the FIFO.
    set_scn(0, 0, 3, 0, -1);
    do_reset();
    run_test(200, 3);
    chk("s3_error", error_flag, 1);
    chk("s3_done", test_done, 1);

    // rd_empty toggling every cycle, random write stalls.
    set_scn(2, 1, 0, 0, -1);
    do_reset();
    run_test(300, 2);
    chk("s4_error", error_flag, 0);
    check_log("s4");

    // Reset mid-write after word 4, then a full rerun.
    set_scn(0, 0, 0, 0, -1);
    do_reset();
    begin
      int n = 0;
      while (m_written < 4 && n < 100) begin cycle(); n++; end
    end
    @(posedge clk); #1;
    chk("s5_pre_rst_wr_en", wr_en, 1);
    do_reset();
    run_test(200, 2);
    check_log("s5");
    chk("s5_error", error_flag, 0);

    // init_done low for 100 cycles.
    set_scn(0, 0, 0, 100, -1);
    do_reset();
    run_test(400, 2);
    chk("s6_first_wr", first_wr_cyc, 100 + SDLY + 1);
    chk("s6_first_wr_ofs", first_wr_cyc - rise_cyc, SDLY + 1);

    // init_done dropped during the start-up delay.
    set_scn(0, 0, 0, 2, 5);
    do_reset();
    run_test(200, 2);
    chk("s7_first_wr", first_wr_cyc, 12);
    chk("s7_first_wr_ofs", first_wr_cyc - rise_cyc, SDLY + 1);

    // Randomized flow control on both FIFOs.
    for (int r = 0; r < 4; r++) begin
      set_scn(2, 2, 0, int'($urandom_range(0, 10)), -1);
      do_reset();
      run_test(400, 3);
      chk("rnd_error", error_flag, 0);
      check_log("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
